// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, op kinds and default timeout.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, IOCTL, CPU, TAPE} arb_state_e;
  typedef enum logic {OP_RD, OP_WR} arb_op_e;
  localparam int TIMEOUT_DEF = 31;
endpackage

// File: rtl/arb_timeout_counter.sv
// Saturating op-age counter; expired stays high once the limit is reached.
module arb_timeout_counter
  import sdram_arb_pkg::*;
#(
  parameter int MAX = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (clear)                   cnt <= '0;
    else if (enable && cnt != LIMIT)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIMIT);
endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between ioctl download, Z80 CPU and tape prefetch.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW      = 25,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_sys,
  input  logic          nRESET,
  input  logic          ioctl_active,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          cpu_rd,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_wait,
  input  logic          nRFSH,
  input  logic          tape_req,
  input  logic [AW-1:0] tape_addr,
  output logic [7:0]    tape_data,
  output logic          tape_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output logic          timeout_err
);
  arb_state_e    state;
  arb_op_e       cpu_op_q, cpu_op;
  logic          cpu_lvl_q, cpu_pend;
  logic [AW-1:0] tape_last;
  logic          cpu_lvl, cpu_edge, cpu_need, tape_elig, idle, busy;
  logic          go_io, go_cpu, go_tape, ack_ok, tmo, tape_abort, finish, expired;

  assign cpu_lvl  = cpu_rd | cpu_we;
  assign cpu_edge = cpu_lvl & ~cpu_lvl_q;
  // The edge cycle itself already counts as pending so the grant is not delayed.
  assign cpu_need = cpu_edge | cpu_pend;
  assign cpu_op   = cpu_edge ? (cpu_we ? OP_WR : OP_RD) : cpu_op_q;
  assign cpu_wait = nRESET & (cpu_need | (state == CPU));

  assign tape_elig = tape_req & ~nRFSH & (tape_addr != tape_last) & ~cpu_need;

  assign idle    = (state == IDLE);
  assign busy    = ~idle;
  assign go_io   = idle & ioctl_active & ioctl_wr;
  assign go_cpu  = idle & ~ioctl_active & cpu_need;
  assign go_tape = idle & ~ioctl_active & tape_elig;

  // An ack coinciding with expiry wins; refresh ending aborts tape without error.
  assign ack_ok     = busy & mem_ack;
  assign tmo        = busy & ~mem_ack & expired;
  assign tape_abort = (state == TAPE) & nRFSH & ~mem_ack & ~expired;
  assign finish     = ack_ok | tmo | tape_abort;

  arb_timeout_counter #(.MAX(TIMEOUT)) u_tmo (
    .clk     (clk_sys),
    .rst_n   (nRESET),
    .clear   (go_io | go_cpu | go_tape),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state       <= IDLE;
      cpu_op_q    <= OP_RD;
      cpu_lvl_q   <= 1'b0;
      cpu_pend    <= 1'b0;
      tape_last   <= '1;
      tape_data   <= '0;
      tape_valid  <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_we      <= 1'b0;
      mem_rd      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cpu_lvl_q   <= cpu_lvl;
      tape_valid  <= 1'b0;
      timeout_err <= 1'b0;
      if (cpu_edge) cpu_op_q <= cpu_op;

      if (cpu_edge)                           cpu_pend <= 1'b1;
      else if ((ack_ok && state == CPU) || tmo) cpu_pend <= 1'b0;

      if (go_io) begin
        state    <= IOCTL;
        mem_addr <= ioctl_addr;
        mem_din  <= ioctl_data;
        mem_we   <= 1'b1;
        mem_rd   <= 1'b0;
      end else if (go_cpu) begin
        state    <= CPU;
        mem_addr <= cpu_addr;
        mem_din  <= cpu_din;
        mem_we   <= (cpu_op == OP_WR);
        mem_rd   <= (cpu_op == OP_RD);
      end else if (go_tape) begin
        state    <= TAPE;
        mem_addr <= tape_addr;
        mem_we   <= 1'b0;
        mem_rd   <= 1'b1;
      end else if (finish) begin
        state  <= IDLE;
        mem_we <= 1'b0;
        mem_rd <= 1'b0;
        if (ack_ok && state == TAPE) begin
          tape_data  <= mem_dout;
          tape_valid <= 1'b1;
          tape_last  <= mem_addr;
        end
        if (tmo) timeout_err <= 1'b1;
      end
    end
  end
endmodule
